// File: rtl/cla_share_if.sv
// Request/grant and result bundle between two adder clients and the shared CLA controller.
// Requesters hold req with stable operands until their gnt pulse; results carry the owner id.
interface cla_share_if #(
    parameter int WIDTH = 16
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             gnt1;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             id;
    logic             done;
    logic             busy;

    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1,
        input  gnt0, gnt1, s, cout, id, done, busy
    );

    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1,
        output gnt0, gnt1, s, cout, id, done, busy
    );
endinterface

// File: rtl/cla_share_ctrl.sv
// Round-robin shares one 4-bit CLA slice between two requesters; done comes N cycles after gnt.
// No grants while RUN: a waiting requester keeps req high and is served at the next IDLE edge.
module cla_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    cla_share_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, ws_q, ws_d, s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, owner_q, owner_d, lp_q, lp_d;
    logic             cout_q, cout_d, id_q, id_d, done_q, done_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;

    logic [3:0]       na, nb, g, p, nsum;
    logic [4:0]       c;
    logic [IW+1:0]    sh;
    logic             win;

    // Flattened lookahead over the nibble selected by idx.
    always_comb begin
        sh   = {idx_q, 2'b00};
        na   = 4'(opa_q >> sh);
        nb   = 4'(opb_q >> sh);
        g    = na & nb;
        p    = na ^ nb;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & c[0]);
        nsum = p ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ws_d    = ws_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        owner_d = owner_q;
        lp_d    = lp_q;
        cout_d  = cout_q;
        id_d    = id_q;
        done_d  = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester not served last wins.
                    win     = (bus.req0 && bus.req1) ? ~lp_q : bus.req1;
                    opa_d   = win ? bus.a1   : bus.a0;
                    opb_d   = win ? bus.b1   : bus.b0;
                    carry_d = win ? bus.cin1 : bus.cin0;
                    owner_d = win;
                    lp_d    = win;
                    idx_d   = '0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    state_d = RUN;
                end
            end
            RUN: begin
                ws_d    = (ws_q & ~(NIB_MASK << sh)) | (WIDTH'(nsum) << sh);
                carry_d = c[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    s_d     = ws_d;
                    cout_d  = c[4];
                    id_d    = owner_q;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            ws_q    <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            owner_q <= 1'b0;
            lp_q    <= 1'b1;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            done_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ws_q    <= ws_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            owner_q <= owner_d;
            lp_q    <= lp_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            done_q  <= done_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign bus.gnt0 = gnt0_q;
    assign bus.gnt1 = gnt1_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.id   = id_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q == RUN);
endmodule
